// File: rtl/computer_system_pio_irq_v2_if.sv
// rtl/computer_system_pio_irq_v2_if.sv - Avalon-MM slave bus for the interrupt PIO
interface computer_system_pio_irq_v2_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/computer_system_pio_irq_v2.sv
// rtl/computer_system_pio_irq_v2.sv - edge-capturing debounced input PIO with masked interrupt
module computer_system_pio_irq_v2 #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int DB_W        = 16
) (
    input  logic                          clk,
    input  logic                          reset_n,
    computer_system_pio_irq_v2_if.slave   bus,
    input  logic [WIDTH-1:0]              in_port,
    output logic                          irq
);

    localparam logic [2:0] A_DATA     = 3'd0;
    localparam logic [2:0] A_RISE_EN  = 3'd1;
    localparam logic [2:0] A_IRQ_MASK = 3'd2;
    localparam logic [2:0] A_EDGE_CAP = 3'd3;
    localparam logic [2:0] A_FALL_EN  = 3'd4;
    localparam logic [2:0] A_DEBOUNCE = 3'd5;
    localparam logic [2:0] A_OVERFLOW = 3'd6;
    localparam logic [2:0] A_INFO     = 3'd7;

    localparam logic [31:0] INFO_WORD = {16'h0, 8'(SYNC_STAGES), 8'(WIDTH)};

    logic [SYNC_STAGES*WIDTH-1:0] sync_chain;
    logic [WIDTH-1:0]             sync_level;
    logic [WIDTH-1:0]             filtered;
    logic [DB_W-1:0]              cnt   [WIDTH];
    logic [DB_W-1:0]              cnt_d [WIDTH];

    logic [WIDTH-1:0] rise_en;
    logic [WIDTH-1:0] fall_en;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] edge_cap;
    logic [WIDTH-1:0] overflow;
    logic [DB_W-1:0]  debounce;

    logic [WIDTH-1:0] upd_evt;
    logic [WIDTH-1:0] edge_evt;
    logic [WIDTH-1:0] cap_clr;
    logic [WIDTH-1:0] ovf_clr;
    logic [WIDTH-1:0] wdata_bits;
    logic             wr_en;
    logic [31:0]      rd_mux;
    logic             unused_wdata;

    assign wr_en        = bus.chipselect & ~bus.write_n;
    assign wdata_bits   = bus.writedata[WIDTH-1:0];
    assign unused_wdata = ^bus.writedata;
    assign sync_level   = sync_chain[SYNC_STAGES*WIDTH-1 -: WIDTH];

    assign cap_clr = (wr_en && bus.address == A_EDGE_CAP) ? wdata_bits : '0;
    assign ovf_clr = (wr_en && bus.address == A_OVERFLOW) ? wdata_bits : '0;

    // Debounce: the counter measures how long sync has disagreed with the filtered level;
    // >= comparison lets a lowered threshold release a pending update on the next cycle.
    always_comb begin
        upd_evt  = '0;
        edge_evt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            if (sync_level[i] != filtered[i]) begin
                if (cnt[i] >= debounce) begin
                    upd_evt[i] = 1'b1;
                end else if (&cnt[i]) begin
                    cnt_d[i] = cnt[i];
                end else begin
                    cnt_d[i] = cnt[i] + DB_W'(1);
                end
            end
            edge_evt[i] = upd_evt[i] &
                          ((sync_level[i] & rise_en[i]) | (~sync_level[i] & fall_en[i]));
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_chain <= '0;
            filtered   <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync_chain <= {sync_chain[(SYNC_STAGES-1)*WIDTH-1:0], in_port};
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= cnt_d[i];
                if (upd_evt[i]) begin
                    filtered[i] <= sync_level[i];
                end
            end
        end
    end

    // Control registers; fall_en resets to all ones to keep the legacy falling-edge behaviour.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rise_en  <= '0;
            fall_en  <= '1;
            irq_mask <= '0;
            debounce <= '0;
        end else if (wr_en) begin
            case (bus.address)
                A_RISE_EN:  rise_en  <= wdata_bits;
                A_FALL_EN:  fall_en  <= wdata_bits;
                A_IRQ_MASK: irq_mask <= wdata_bits;
                A_DEBOUNCE: debounce <= bus.writedata[DB_W-1:0];
                default: ;
            endcase
        end
    end

    // New events win over a same-cycle clear so no edge is ever silently dropped.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edge_cap <= '0;
            overflow <= '0;
        end else begin
            edge_cap <= (edge_cap & ~cap_clr) | edge_evt;
            overflow <= (overflow & ~ovf_clr) | (edge_evt & edge_cap & ~cap_clr);
        end
    end

    always_comb begin
        rd_mux = '0;
        case (bus.address)
            A_DATA:     rd_mux = 32'(filtered);
            A_RISE_EN:  rd_mux = 32'(rise_en);
            A_IRQ_MASK: rd_mux = 32'(irq_mask);
            A_EDGE_CAP: rd_mux = 32'(edge_cap);
            A_FALL_EN:  rd_mux = 32'(fall_en);
            A_DEBOUNCE: rd_mux = 32'(debounce);
            A_OVERFLOW: rd_mux = 32'(overflow);
            A_INFO:     rd_mux = INFO_WORD;
            default:    rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.readdata <= '0;
        end else begin
            bus.readdata <= rd_mux;
        end
    end

    assign irq = |(edge_cap & irq_mask);

endmodule

// File: tb/tb_computer_system_pio_irq_v2.sv
// tb/tb_computer_system_pio_irq_v2.sv - scoreboard bench for the interrupt PIO
module tb_computer_system_pio_irq_v2;

    typedef struct {
        string       name;
        logic [31:0] exp;
        bit          is_irq;
    } sb_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] in_port = '0;
    logic       irq;
    logic       rd_req = 1'b0;
    logic       req_q = 1'b0;
    int         checks = 0;
    int         errors = 0;
    sb_t        sb_q[$];
    event       async_ev;

    computer_system_pio_irq_v2_if bus_if ();

    computer_system_pio_irq_v2 #(.WIDTH(8), .SYNC_STAGES(2), .DB_W(16)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_if.slave),
        .in_port (in_port),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    task automatic compare_one();
        sb_t         it;
        logic [31:0] act;
        if (sb_q.size() == 0) begin
            errors++;
            checks++;
            $display("FAIL scoreboard_underflow: output presented with no expectation queued");
        end else begin
            it  = sb_q.pop_front();
            act = it.is_irq ? {31'b0, irq} : bus_if.readdata;
            checks++;
            if (act !== it.exp) begin
                errors++;
                $display("FAIL %s: got 0x%08h expected 0x%08h", it.name, act, it.exp);
            end
        end
    endtask

    always @(posedge clk) req_q <= rd_req;

    always @(negedge clk) begin
        if (req_q) compare_one();
    end

    always @(async_ev) begin
        while (sb_q.size() > 0) compare_one();
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        bus_if.chipselect = 1'b1;
        bus_if.write_n    = 1'b0;
        bus_if.address    = a;
        bus_if.writedata  = d;
        @(negedge clk);
        bus_if.chipselect = 1'b0;
        bus_if.write_n    = 1'b1;
        bus_if.writedata  = '0;
    endtask

    task automatic rd(input logic [2:0] a, input logic [31:0] e, input string nm);
        bus_if.address = a;
        sb_q.push_back('{name: nm, exp: e, is_irq: 1'b0});
        rd_req = 1'b1;
        @(negedge clk);
        rd_req = 1'b0;
    endtask

    task automatic chk_irq(input logic e, input string nm);
        sb_q.push_back('{name: nm, exp: {31'b0, e}, is_irq: 1'b1});
        rd_req = 1'b1;
        @(negedge clk);
        rd_req = 1'b0;
    endtask

    task automatic read_defaults(input string tag);
        logic [31:0] dflt [8];
        dflt = '{32'h0, 32'h0, 32'h0, 32'h0, 32'hFF, 32'h0, 32'h0, 32'h0000_0208};
        for (int a = 0; a < 8; a++) begin
            rd(3'(a), dflt[a], $sformatf("%s_reg%0d", tag, a));
        end
        chk_irq(1'b0, {tag, "_irq"});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bus_if.address    = '0;
        bus_if.chipselect = 1'b0;
        bus_if.write_n    = 1'b1;
        bus_if.writedata  = '0;
        idle(3);
        reset_n = 1'b1;
        read_defaults("rst");

        // legacy falling edge on bit0, D = 0
        wr(2, 32'h01);
        in_port = 8'h01;
        idle(4);
        rd(0, 32'h01, "fall_data_high");
        rd(3, 32'h00, "fall_no_rise_cap");
        in_port = 8'h00;
        chk_irq(1'b0, "fall_irq_k");
        chk_irq(1'b0, "fall_irq_k1");
        chk_irq(1'b1, "fall_irq_k2");
        rd(3, 32'h01, "fall_cap");
        wr(3, 32'h01);
        chk_irq(1'b0, "fall_irq_cleared");
        rd(3, 32'h00, "fall_cap_cleared");

        // rising and falling capture on bit1, bit2 disabled
        wr(1, 32'h02);
        wr(4, 32'h02);
        in_port = 8'h02;
        idle(4);
        rd(3, 32'h02, "both_rise_cap");
        wr(3, 32'h02);
        rd(3, 32'h00, "both_clr1");
        in_port = 8'h00;
        idle(4);
        rd(3, 32'h02, "both_fall_cap");
        rd(6, 32'h00, "both_no_ovf");
        wr(3, 32'h02);
        in_port = 8'h04;
        idle(4);
        in_port = 8'h00;
        idle(4);
        rd(3, 32'h00, "bit2_no_cap");
        chk_irq(1'b0, "both_irq_masked");

        // debounce D = 5: 4-cycle glitch rejected, steady level accepted after 6 cycles
        wr(5, 32'h5);
        rd(5, 32'h5, "db_reg");
        in_port = 8'h08;
        idle(4);
        in_port = 8'h00;
        idle(8);
        rd(0, 32'h00, "db_glitch_data");
        rd(3, 32'h00, "db_glitch_cap");
        in_port = 8'h08;
        for (int i = 0; i <= 8; i++) begin
            rd(0, (i == 8) ? 32'h08 : 32'h00, $sformatf("db_level_%0d", i));
        end
        idle(2);
        in_port = 8'h00;
        idle(12);
        wr(5, 32'h0);
        rd(0, 32'h00, "db_release");

        // overflow on bit0, then clear/new-edge race
        wr(1, 32'h01);
        wr(4, 32'h01);
        in_port = 8'h01;
        idle(4);
        in_port = 8'h00;
        idle(4);
        rd(6, 32'h01, "ovf_set");
        rd(3, 32'h01, "ovf_cap");
        wr(6, 32'h01);
        rd(6, 32'h00, "ovf_cleared");
        in_port = 8'h01;
        idle(2);
        wr(3, 32'h01);
        rd(3, 32'h01, "race_cap_kept");
        rd(6, 32'h00, "race_ovf_unchanged");
        chk_irq(1'b1, "race_irq");

        // async reset with EDGE_CAP full
        wr(1, 32'hFF);
        in_port = 8'hFF;
        idle(4);
        wr(2, 32'hFF);
        rd(3, 32'hFF, "pre_rst_cap");
        chk_irq(1'b1, "pre_rst_irq");
        #2;
        reset_n = 1'b0;
        in_port = 8'h00;
        #1;
        sb_q.push_back('{name: "async_irq", exp: 32'h0, is_irq: 1'b1});
        sb_q.push_back('{name: "async_rdata", exp: 32'h0, is_irq: 1'b0});
        ->async_ev;
        #1;
        idle(2);
        reset_n = 1'b1;
        read_defaults("arst");

        idle(3);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d left, expected 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
